char_pixel_serializer: RTL



---
 rtl/char_pixel_serializer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/char_pixel_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// char_pixel_serializer : text-mode glyph fetch, pixel shift-out, blinking
//                         block cursor and 3-cycle sync/active delay line.
// Revision: 1.0
// ---------------------------------------------------------------------------
module char_pixel_serializer #(
   parameter logic [7:0]  FG_COLOR     = 8'hFF,
   parameter logic [7:0]  BG_COLOR     = 8'h00,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic       pixelClk,
   input  logic       resetN,
   input  logic       inActive,
   input  logic       inHsync,
   input  logic       inVsync,
   input  logic [9:0] inHCount,
   input  logic [9:0] inVCount,
   input  logic [1:0] inCharCode,
   input  logic [6:0] inCursorCol,
   input  logic [4:0] inCursorRow,
   input  logic       inCursorEn,
   output logic [5:0] outRomAddress,
   input  logic [7:0] inRomData,
   output logic [7:0] outRgb,
   output logic       outHsync,
   output logic       outVsync,
   output logic       outActive
);

   localparam logic [7:0] C_BLINK_LAST = 8'(BLINK_FRAMES - 1);

   logic [5:0] rom_addr_q, rom_addr_d;
   logic       load1_q, load1_d;
   logic       hit1_q, hit1_d;
   logic       load2_q, load2_d;
   logic       hit2_q, hit2_d;
   logic [7:0] shift_q, shift_d;
   logic       cursor_latch_q, cursor_latch_d;
   logic [7:0] rgb_q, rgb_d;
   logic [2:0] act_dly_q, act_dly_d;
   logic [2:0] hs_dly_q, hs_dly_d;
   logic [2:0] vs_dly_q, vs_dly_d;
   logic       vs_prev_q, vs_prev_d;
   logic [7:0] blink_cnt_q, blink_cnt_d;
   logic       blink_phase_q, blink_phase_d;

   logic       w_cell_start;
   logic       w_pix;
   logic       w_cur;
   logic       unused_vcount_msb;

   assign unused_vcount_msb = inVCount[9];

   always_comb begin
      rom_addr_d     = rom_addr_q;
      load1_d        = 1'b0;
      hit1_d         = 1'b0;
      load2_d        = load1_q;
      hit2_d         = hit1_q;
      shift_d        = shift_q;
      cursor_latch_d = cursor_latch_q;
      rgb_d          = 8'h00;
      act_dly_d      = {act_dly_q[1:0], inActive};
      hs_dly_d       = {hs_dly_q[1:0], inHsync};
      vs_dly_d       = {vs_dly_q[1:0], inVsync};
      vs_prev_d      = inVsync;
      blink_cnt_d    = blink_cnt_q;
      blink_phase_d  = blink_phase_q;
      w_pix          = 1'b0;
      w_cur          = 1'b0;

      w_cell_start = inActive && (inHCount[2:0] == 3'd0);
      if (w_cell_start) begin
         rom_addr_d = {inCharCode, inVCount[3:0]};
         load1_d    = 1'b1;
         hit1_d     = inCursorEn && (inHCount[9:3] == inCursorCol)
                                 && (inVCount[8:4] == inCursorRow);
      end

      // On a load the glyph MSB goes straight to the colour register so the
      // shifter only keeps the 7 remaining bits; this holds total latency at 3.
      if (load2_q) begin
         w_pix          = inRomData[7];
         w_cur          = hit2_q;
         shift_d        = {inRomData[6:0], 1'b0};
         cursor_latch_d = hit2_q;
      end else begin
         w_pix   = shift_q[7];
         w_cur   = cursor_latch_q;
         shift_d = {shift_q[6:0], 1'b0};
      end

      if (act_dly_q[1]) begin
         rgb_d = (w_pix ^ (w_cur & blink_phase_q)) ? FG_COLOR : BG_COLOR;
      end

      if (vs_prev_q && !inVsync) begin
         if (blink_cnt_q == C_BLINK_LAST) begin
            blink_cnt_d   = 8'd0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge pixelClk) begin
      if (!resetN) begin
         rom_addr_q     <= 6'd0;
         load1_q        <= 1'b0;
         hit1_q         <= 1'b0;
         load2_q        <= 1'b0;
         hit2_q         <= 1'b0;
         shift_q        <= 8'd0;
         cursor_latch_q <= 1'b0;
         rgb_q          <= 8'd0;
         act_dly_q      <= 3'b000;
         hs_dly_q       <= 3'b111;
         vs_dly_q       <= 3'b111;
         vs_prev_q      <= 1'b1;
         blink_cnt_q    <= 8'd0;
         blink_phase_q  <= 1'b0;
      end else begin
         rom_addr_q     <= rom_addr_d;
         load1_q        <= load1_d;
         hit1_q         <= hit1_d;
         load2_q        <= load2_d;
         hit2_q         <= hit2_d;
         shift_q        <= shift_d;
         cursor_latch_q <= cursor_latch_d;
         rgb_q          <= rgb_d;
         act_dly_q      <= act_dly_d;
         hs_dly_q       <= hs_dly_d;
         vs_dly_q       <= vs_dly_d;
         vs_prev_q      <= vs_prev_d;
         blink_cnt_q    <= blink_cnt_d;
         blink_phase_q  <= blink_phase_d;
      end
   end

   assign outRomAddress = rom_addr_q;
   assign outRgb        = rgb_q;
   assign outActive     = act_dly_q[2];
   assign outHsync      = hs_dly_q[2];
   assign outVsync      = vs_dly_q[2];

endmodule
`default_nettype wire
